// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  // Occupancy counter must hold 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Default almost_full threshold sits two entries below full.
  function automatic int af_level_default(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port; a same-address read in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port; output holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy, threshold and sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = af_level_default(DEPTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   re,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q;
  logic              overflow_q, underflow_q;
  logic              out_clr_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // A write is allowed into a full FIFO only when a read frees a slot in the same cycle.
  assign rd_acc = re && !empty;
  assign wr_acc = we && (!full || rd_acc);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
  end

  // Control state; reset discards queued data by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      out_clr_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (we && !wr_acc)  overflow_q  <= 1'b1;
      if (re && empty)    underflow_q <= 1'b1;
      if (rd_acc)         out_clr_q   <= 1'b0;
    end
  end

  // Storage is not reset; reset simply blocks any access that cycle.
  fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (wr_acc && !rst),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(data_in),
    .rd_en_i  (rd_acc && !rst),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(ram_rdata)
  );

  // The RAM output register has no reset, so a registered clear flag forces zero until the first read.
  assign data_out     = out_clr_q ? '0 : ram_rdata;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DATA_W=8, DEPTH=16, AF=14, AE=2).
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(
    .DATA_W  (8),
    .DEPTH   (16),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .data_in     (data_in),
    .re          (re),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: count=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0",
               count, empty, almost_empty, full, almost_full);
    end
    checks++;
    if (data_out !== 8'h00 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: dout=%h rv=%b ov=%b un=%b, want 00 0 0 0",
               data_out, rd_valid, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; data_in = 8'(i);
      step();
      checks++;
      if (count !== 5'(i) || almost_full !== (i >= 14) || full !== (i == 16) ||
          empty !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d af=%b f=%b e=%b ov=%b, want %0d %b %b 0 0",
                 i, count, almost_full, full, empty, overflow, i, (i >= 14), (i == 16));
      end
    end
    data_in = 8'h77;
    step();
    we = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: ov=%b count=%0d f=%b, want 1 16 1", overflow, count, full);
    end
  endtask

  // Continues from the full FIFO left by test_fill; 0x77 must not appear.
  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      re = 1'b1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || data_out !== 8'(i) || count !== 5'(16 - i) ||
          empty !== (i == 16) || almost_empty !== (16 - i <= 2)) begin
        errors++;
        $display("FAIL drain_%0d: rv=%b dout=%h count=%0d e=%b ae=%b, want 1 %h %0d %b",
                 i, rd_valid, data_out, count, empty, almost_empty, 8'(i), 16 - i, (i == 16));
      end
    end
    re = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 8'h10 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: rv=%b dout=%h un=%b, want 0 10 0", rd_valid, data_out, underflow);
    end
    re = 1'b1;
    step();
    re = 1'b0;
    checks++;
    if (underflow !== 1'b1 || data_out !== 8'h10 || rd_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL drain_underflow: un=%b dout=%h rv=%b count=%0d, want 1 10 0 0",
               underflow, data_out, rd_valid, count);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; data_in = 8'(i);
      step();
    end
    we = 1'b1; re = 1'b1; data_in = 8'hAA;
    step();
    we = 1'b0; re = 1'b0;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || data_out !== 8'h01 || rd_valid !== 1'b1 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: count=%0d f=%b dout=%h rv=%b ov=%b, want 16 1 01 1 0",
               count, full, data_out, rd_valid, overflow);
    end
    for (int i = 2; i <= 17; i++) begin
      re = 1'b1;
      step();
      checks++;
      if (data_out !== ((i == 17) ? 8'hAA : 8'(i)) || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_rw_rd_%0d: dout=%h rv=%b, want %h 1",
                 i, data_out, rd_valid, (i == 17) ? 8'hAA : 8'(i));
      end
    end
    re = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw_end: e=%b ov=%b un=%b, want 1 0 0", empty, overflow, underflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      we = 1'b1; data_in = 8'(i);
      step();
    end
    for (int j = 0; j < 40; j++) begin
      we = 1'b1; re = 1'b1; data_in = 8'(j + 4);
      step();
      checks++;
      if (data_out !== 8'(j + 1) || rd_valid !== 1'b1 || count !== 5'd3) begin
        errors++;
        $display("FAIL b2b_%0d: dout=%h rv=%b count=%0d, want %h 1 3",
                 j, data_out, rd_valid, count, 8'(j + 1));
      end
    end
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      we = 1'b1; data_in = 8'(8'h30 + i);
      step();
    end
    we = 1'b0; re = 1'b1;
    step();
    re = 1'b0;
    checks++;
    if (count !== 5'd9 || data_out !== 8'h31) begin
      errors++;
      $display("FAIL mid_pre: count=%0d dout=%h, want 9 31", count, data_out);
    end
    rst = 1'b1; we = 1'b1; re = 1'b1; data_in = 8'hEE;
    step();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 ||
        data_out !== 8'h00 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b dout=%h rv=%b, want 0 1 1 0 0 0 0 00 0",
               count, empty, almost_empty, full, almost_full, overflow, underflow, data_out, rd_valid);
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    we = 1'b1; re = 1'b1; data_in = 8'h5A;
    step();
    we = 1'b0; re = 1'b0;
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: count=%0d un=%b rv=%b e=%b ov=%b, want 1 1 0 0 0",
               count, underflow, rd_valid, empty, overflow);
    end
    re = 1'b1;
    step();
    re = 1'b0;
    checks++;
    if (data_out !== 8'h5A || rd_valid !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_read: dout=%h rv=%b e=%b, want 5a 1 1", data_out, rd_valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_back_to_back();
    test_reset_mid();
    test_empty_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
